program_loader: RTL
===================

Name: program_loader

Overview:
- Writer side of the instruction path: turns a byte stream (from the UART receiver) into 16-bit instruction words {opcode[4:0], operand[10:0]}.
- Writes the words sequentially into program memory. The instruction decoder later fetches and decodes them.
- Holds the CPU stopped while loading. Releases it once the HLT word (opcode 5'b00000) has been stored.

Parameters:
- ADDR_W, 11, program memory address width.
- MEM_DEPTH, 2048, number of program words; must be ≤ 2^ADDR_W.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load. Ignored outside IDLE.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle.
- prog_addr  out  ADDR_W  program memory write address.
- prog_data  out  16  program memory write data.
- prog_we  out  1  program memory write enable, one-cycle pulse.
- busy  out  1  high from accepted start until DONE or ERROR.
- cpu_run  out  1  high in DONE; enables the CPU PC.
- done  out  1  high in DONE.
- err  out  1  high in ERROR.

Behaviour:
- Reset is asynchronous, active-high, with one clock.
- Reset values: state=IDLE, prog_addr=0, prog_data=0, prog_we=0, busy=0, cpu_run=0, done=0, err=0.
- Reset mid-load aborts immediately to IDLE. Memory contents already written are not cleared.
- States: IDLE, WAIT_HI, WAIT_LO, WRITE, DONE, ERROR.
- IDLE:
  - start → WAIT_HI, with prog_addr=0 and busy=1.
  - rx_valid is ignored.
- WAIT_HI: on rx_valid, latch the byte into prog_data[15:8] → WAIT_LO.
  - prog_data[15:11] is the opcode; prog_data[10:8] is operand[10:8].
- WAIT_LO: on rx_valid, latch the byte into prog_data[7:0] → WRITE.
- WRITE: prog_we=1 for exactly this one cycle, using the current prog_addr and prog_data. Priority order:
  - Opcode = 00000 (HLT) → DONE.
  - Otherwise, prog_addr = MEM_DEPTH-1 → ERROR (memory full, no HLT).
  - Otherwise, prog_addr increments by 1 → WAIT_HI. If rx_valid is high in this same cycle, that byte is taken as the next high byte → WAIT_LO.
- Timing: write pulse one cycle after the low byte's rx_valid. prog_addr updates on the cycle after the pulse.
- DONE: done=1, cpu_run=1, busy=0. Holds until reset; start and rx_valid are ignored.
- ERROR: err=1, busy=0, cpu_run=0. Holds until reset.
- prog_we is never high outside WRITE.
- prog_addr never wraps. Overflow always goes to ERROR.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of every data byte accepted since start is kept; it is cleared on start.
  - After the HLT write, go to CHK instead of DONE.
  - In CHK, the next rx_valid byte is compared against the running XOR: equal → DONE; not equal → ERROR.
- Undefined: no CHK state; HLT → DONE as described above.

Test Plan:
- Reset, start, bytes 0x18,0x05,0x00,0x00 → prog_we pulses at addr 0 data 0x1805 (LDI 5) and at addr 1 data 0x0000; then done=1, cpu_run=1, busy=0.
- Bytes 0x20,0x07,0x08,0x03,0x00,0x00 → writes 0x2007 (ADD 7) @0, 0x0803 (STO 3) @1, 0x0000 @2; done after the third pulse.
- Byte on rx_valid in the same cycle as WRITE → it becomes the next high byte; no byte lost, next word correct.
- MEM_DEPTH=4, load four non-HLT words → four writes at addresses 0–3, then err=1, no fifth write, cpu_run=0.
- Assert reset after 0x18 only, then start, 0x00,0x00 → single write 0x0000 @0, done=1; stale byte not used.
- With PROG_LOADER_CHECKSUM_EN: bytes 0x18,0x05,0x00,0x00 then 0x1D → done=1; repeat with 0x1C → err=1.

Source files
------------

// File: rtl/program_loader.sv
// Assembles a received byte stream into 16-bit program words and writes them
// sequentially into program memory. Optional checksum stage: PROG_LOADER_CHECKSUM_EN.
module program_loader #(
   parameter int ADDR_W    = 11,
   parameter int MEM_DEPTH = 2048
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic [ADDR_W-1:0] prog_addr,
   output logic [15:0]       prog_data,
   output logic              prog_we,
   output logic              busy,
   output logic              cpu_run,
   output logic              done,
   output logic              err
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

`ifdef PROG_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, WAIT_HI, WAIT_LO, WRITE, DONE, ERROR, CHK} state_t;
   logic [7:0] checksumReg, checksumNext;
`else
   typedef enum logic [2:0] {IDLE, WAIT_HI, WAIT_LO, WRITE, DONE, ERROR} state_t;
`endif

   state_t            stateReg, stateNext;
   logic [ADDR_W-1:0] progAddrReg, progAddrNext;
   logic [15:0]       progDataReg, progDataNext;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stateReg    <= IDLE;
         progAddrReg <= '0;
         progDataReg <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
         checksumReg <= '0;
`endif
      end else begin
         stateReg    <= stateNext;
         progAddrReg <= progAddrNext;
         progDataReg <= progDataNext;
`ifdef PROG_LOADER_CHECKSUM_EN
         checksumReg <= checksumNext;
`endif
      end
   end

   always_comb begin
      stateNext    = stateReg;
      progAddrNext = progAddrReg;
      progDataNext = progDataReg;
`ifdef PROG_LOADER_CHECKSUM_EN
      checksumNext = checksumReg;
`endif
      case (stateReg)
         IDLE: begin
            if (start) begin
               stateNext    = WAIT_HI;
               progAddrNext = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
               checksumNext = '0;
`endif
            end
         end
         WAIT_HI: begin
            if (rx_valid) begin
               progDataNext = {rx_data, progDataReg[7:0]};
               stateNext    = WAIT_LO;
`ifdef PROG_LOADER_CHECKSUM_EN
               checksumNext = checksumReg ^ rx_data;
`endif
            end
         end
         WAIT_LO: begin
            if (rx_valid) begin
               progDataNext = {progDataReg[15:8], rx_data};
               stateNext    = WRITE;
`ifdef PROG_LOADER_CHECKSUM_EN
               checksumNext = checksumReg ^ rx_data;
`endif
            end
         end
         WRITE: begin
            // HLT wins over memory-full so a HLT in the last slot still completes
            if (progDataReg[15:11] == 5'b00000) begin
`ifdef PROG_LOADER_CHECKSUM_EN
               stateNext = CHK;
`else
               stateNext = DONE;
`endif
            end else if (progAddrReg == LAST_ADDR) begin
               stateNext = ERROR;
            end else begin
               progAddrNext = progAddrReg + ADDR_W'(1);
               if (rx_valid) begin
                  progDataNext = {rx_data, progDataReg[7:0]};
                  stateNext    = WAIT_LO;
`ifdef PROG_LOADER_CHECKSUM_EN
                  checksumNext = checksumReg ^ rx_data;
`endif
               end else begin
                  stateNext = WAIT_HI;
               end
            end
         end
`ifdef PROG_LOADER_CHECKSUM_EN
         CHK: begin
            if (rx_valid) begin
               stateNext = (rx_data == checksumReg) ? DONE : ERROR;
            end
         end
`endif
         DONE:    stateNext = DONE;
         ERROR:   stateNext = ERROR;
         default: stateNext = IDLE;
      endcase
   end

   always_comb begin
      prog_addr = progAddrReg;
      prog_data = progDataReg;
      prog_we   = (stateReg == WRITE);
      done      = (stateReg == DONE);
      cpu_run   = (stateReg == DONE);
      err       = (stateReg == ERROR);
`ifdef PROG_LOADER_CHECKSUM_EN
      busy      = (stateReg == WAIT_HI) || (stateReg == WAIT_LO) ||
                  (stateReg == WRITE)   || (stateReg == CHK);
`else
      busy      = (stateReg == WAIT_HI) || (stateReg == WAIT_LO) ||
                  (stateReg == WRITE);
`endif
   end

endmodule
